// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle of bin2bcd_seq; BIN2BCD_SIGNED_EN adds the neg result bit.
interface bin2bcd_if
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
);
   logic                        start;
   logic [BIN_W-1:0]            bin;
   logic                        busy;
   logic                        done;
   logic [DIGIT_W*DIGITS-1:0]   bcd;
   logic                        overflow;
`ifdef BIN2BCD_SIGNED_EN
   logic                        neg;
`endif

   modport master (
      output start, output bin,
      input  busy, input done, input bcd, input overflow
`ifdef BIN2BCD_SIGNED_EN
      , input neg
`endif
   );

   modport slave (
      input  start, input bin,
      output busy, output done, output bcd, output overflow
`ifdef BIN2BCD_SIGNED_EN
      , output neg
`endif
   );

endinterface

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_dabble_digit
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
// Optional macro BIN2BCD_SIGNED_EN: two's complement input, magnitude result plus neg.
//
//   state | meaning
//   IDLE  | waiting for start; operand captured on the accepting edge
//   SHIFT | BIN_W correct-and-shift iterations, busy high
//   DONE  | one-cycle done pulse, results valid
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
)(
   input  logic      clk,
   input  logic      rst_n,
   bin2bcd_if.slave  bus
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = DIGIT_W * DIGITS;
   // Overflow can only happen if the largest input needs more than DIGITS digits.
   localparam bit OVF_POSSIBLE = pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [BIN_W-1:0]   sr;
   logic [BCD_W-1:0]   scratch;
   logic               ovf_s;
   logic [BCD_W-1:0]   corr;
   logic [BCD_W-1:0]   scratch_next;
   logic               ovf_next;
   logic [BIN_W-1:0]   bin_mag;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_dabble_digit u_digit (
         .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
         .digit_out (corr[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign scratch_next = {corr[BCD_W-2:0], sr[BIN_W-1]};
   assign ovf_next     = ovf_s | corr[BCD_W-1];

`ifdef BIN2BCD_SIGNED_EN
   logic neg_s;
   logic neg_q;
   // -2^(BIN_W-1) negates to itself, which is the right unsigned magnitude.
   assign bin_mag = bus.bin[BIN_W-1] ? (~bus.bin + BIN_W'(1)) : bus.bin;
   assign bus.neg = neg_q;
`else
   assign bin_mag = bus.bin;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         sr           <= '0;
         scratch      <= '0;
         ovf_s        <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd      <= '0;
         bus.overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
         neg_s        <= 1'b0;
         neg_q        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  sr       <= bin_mag;
                  scratch  <= '0;
                  ovf_s    <= 1'b0;
                  cnt      <= CNT_W'(BIN_W);
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                  neg_s    <= bus.bin[BIN_W-1];
`endif
               end
            end
            SHIFT: begin
               scratch <= scratch_next;
               sr      <= {sr[BIN_W-2:0], 1'b0};
               ovf_s   <= ovf_next;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bus.bcd      <= scratch_next;
                  bus.overflow <= OVF_POSSIBLE ? ovf_next : 1'b0;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= DONE;
`ifdef BIN2BCD_SIGNED_EN
                  neg_q        <= neg_s;
`endif
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default 14-bit/4-digit instance and an 8-bit/3-digit instance.
module tb_bin2bcd_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bin2bcd_if #(.BIN_W(14), .DIGITS(4)) bus  ();
   bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) bus8 ();

   bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one conversion on the 14-bit instance; lat is the negedge index
   // (counted after the accepting edge) where done is first seen, -1 on timeout.
   task automatic run_conv(input logic [13:0] b, output int lat, output bit bcd_moved);
      logic [15:0] bcd0;
      lat = -1;
      bcd_moved = 1'b0;
      bcd0 = bus.bcd;
      bus.start = 1'b1;
      bus.bin   = b;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.start = 1'b0;
            bus.bin   = ~b;
         end
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
         if (bus.bcd !== bcd0) bcd_moved = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic run_conv8(input logic [7:0] b, output int lat);
      lat = -1;
      bus8.start = 1'b1;
      bus8.bin   = b;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus8.start = 1'b0;
            bus8.bin   = ~b;
         end
         if (bus8.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.bin = '0;
      bus8.start = 1'b0; bus8.bin = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.overflow, bus.bcd} !== 19'd0) begin
         errors++;
         $display("FAIL reset14 busy/done/ovf/bcd got %b %b %b %h want 0 0 0 0000",
                  bus.busy, bus.done, bus.overflow, bus.bcd);
      end
      checks++;
      if ({bus8.busy, bus8.done, bus8.overflow, bus8.bcd} !== 15'd0) begin
         errors++;
         $display("FAIL reset8 busy/done/ovf/bcd got %b %b %b %h want 0 0 0 000",
                  bus8.busy, bus8.done, bus8.overflow, bus8.bcd);
      end
`ifdef BIN2BCD_SIGNED_EN
      checks++;
      if (bus.neg !== 1'b0) begin
         errors++;
         $display("FAIL reset_neg got %b want 0", bus.neg);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [13:0] vin [4];
      logic [15:0] vbcd [4];
      logic        vovf [4];
      logic        vneg [4];
      int lat;
      bit moved;
      vin[0] = 14'd9999;  vin[1] = 14'd0;  vin[2] = 14'd16383; vin[3] = 14'd42;
`ifdef BIN2BCD_SIGNED_EN
      vbcd[0] = 16'h6385; vovf[0] = 1'b0; vneg[0] = 1'b1;
      vbcd[1] = 16'h0000; vovf[1] = 1'b0; vneg[1] = 1'b0;
      vbcd[2] = 16'h0001; vovf[2] = 1'b0; vneg[2] = 1'b1;
      vbcd[3] = 16'h0042; vovf[3] = 1'b0; vneg[3] = 1'b0;
`else
      vbcd[0] = 16'h9999; vovf[0] = 1'b0; vneg[0] = 1'b0;
      vbcd[1] = 16'h0000; vovf[1] = 1'b0; vneg[1] = 1'b0;
      vbcd[2] = 16'h6383; vovf[2] = 1'b1; vneg[2] = 1'b0;
      vbcd[3] = 16'h0042; vovf[3] = 1'b0; vneg[3] = 1'b0;
`endif
      for (int k = 0; k < 4; k++) begin
         run_conv(vin[k], lat, moved);
         checks++;
         if (lat !== 15) begin
            errors++;
            $display("FAIL latency bin=%0d got %0d want 15", vin[k], lat);
         end
         checks++;
         if (bus.bcd !== vbcd[k] || bus.overflow !== vovf[k]) begin
            errors++;
            $display("FAIL result bin=%0d got bcd=%h ovf=%b want bcd=%h ovf=%b",
                     vin[k], bus.bcd, bus.overflow, vbcd[k], vovf[k]);
         end
         checks++;
         if (k > 0 && moved) begin
            errors++;
            $display("FAIL bcd_stable bin=%0d got changed during SHIFT want held", vin[k]);
         end
`ifdef BIN2BCD_SIGNED_EN
         checks++;
         if (bus.neg !== vneg[k]) begin
            errors++;
            $display("FAIL neg bin=%0d got %b want %b", vin[k], bus.neg, vneg[k]);
         end
`else
         if (vneg[k] !== 1'b0) $display("unexpected signed vector");
`endif
      end
   endtask

   task automatic test_back_to_back();
      int npulse;
      int p [3];
      npulse = 0;
      p[0] = 0; p[1] = 0; p[2] = 0;
      bus.start = 1'b1;
      bus.bin   = 14'd1234;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (npulse < 3) p[npulse] = i;
            npulse++;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (npulse != 2) begin
         errors++;
         $display("FAIL b2b_count got %0d want 2", npulse);
      end
      checks++;
      if (p[0] != 15 || p[1] - p[0] != 16) begin
         errors++;
         $display("FAIL b2b_spacing got first=%0d gap=%0d want 15 16", p[0], p[1] - p[0]);
      end
      checks++;
      if (bus.bcd !== 16'h1234) begin
         errors++;
         $display("FAIL b2b_bcd got %h want 1234", bus.bcd);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int ndone;
      int lat;
      bit moved;
      ndone = 0;
      bus.start = 1'b1;
      bus.bin   = 14'd9999;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.bcd !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset got busy=%b bcd=%h want 0 0000", bus.busy, bus.bcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0 || bus.bcd !== 16'h0000 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL abort got done_pulses=%0d bcd=%h ovf=%b want 0 0000 0",
                  ndone, bus.bcd, bus.overflow);
      end
      run_conv(14'd42, lat, moved);
      checks++;
      if (lat !== 15 || bus.bcd !== 16'h0042) begin
         errors++;
         $display("FAIL after_reset got lat=%0d bcd=%h want 15 0042", lat, bus.bcd);
      end
   endtask

`ifdef BIN2BCD_SIGNED_EN
   task automatic test_signed();
      int lat;
      bit moved;
      run_conv(14'h2000, lat, moved);
      checks++;
      if (bus.neg !== 1'b1 || bus.bcd !== 16'h8192 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL signed_min got neg=%b bcd=%h ovf=%b want 1 8192 0",
                  bus.neg, bus.bcd, bus.overflow);
      end
      run_conv(14'h3FFF, lat, moved);
      checks++;
      if (bus.neg !== 1'b1 || bus.bcd !== 16'h0001) begin
         errors++;
         $display("FAIL signed_m1 got neg=%b bcd=%h want 1 0001", bus.neg, bus.bcd);
      end
      run_conv(14'd0, lat, moved);
      checks++;
      if (bus.neg !== 1'b0 || bus.bcd !== 16'h0000) begin
         errors++;
         $display("FAIL signed_zero got neg=%b bcd=%h want 0 0000", bus.neg, bus.bcd);
      end
   endtask
`endif

   task automatic test_exhaustive8();
      int lat;
      int mag;
      logic [11:0] exp_bcd;
      logic        exp_neg;
      for (int b = 0; b < 256; b++) begin
`ifdef BIN2BCD_SIGNED_EN
         exp_neg = (b >= 128);
         mag = exp_neg ? 256 - b : b;
`else
         exp_neg = 1'b0;
         mag = b;
`endif
         exp_bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
         run_conv8(8'(b), lat);
         checks++;
         if (lat !== 9 || bus8.bcd !== exp_bcd || bus8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL exh8 bin=%0d got lat=%0d bcd=%h ovf=%b want 9 %h 0",
                     b, lat, bus8.bcd, bus8.overflow, exp_bcd);
         end
`ifdef BIN2BCD_SIGNED_EN
         checks++;
         if (bus8.neg !== exp_neg) begin
            errors++;
            $display("FAIL exh8_neg bin=%0d got %b want %b", b, bus8.neg, exp_neg);
         end
`else
         if (exp_neg !== 1'b0) $display("unexpected signed model");
`endif
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.start = 1'b0; bus.bin = '0;
      bus8.start = 1'b0; bus8.bin = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_abort();
`ifdef BIN2BCD_SIGNED_EN
      test_signed();
`endif
      test_exhaustive8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 14, giving the binary input width (legal range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of BCD output digits (legal range 1..10).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bin, input, BIN_W bits: binary operand, captured on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: result, digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port overflow, output, 1 bit: result exceeds 10^DIGITS-1; valid with bcd.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, DONE: IDLE->SHIFT on start=1; SHIFT->DONE after the final iteration; DONE->IDLE unconditionally after one cycle.
REQ-012 On accepting start, the block SHALL load bin into a shift register, clear the BCD scratch digits and overflow scratch, and load the iteration counter with BIN_W.
REQ-013 Each SHIFT cycle SHALL: add 3 to every scratch digit >= 5, then shift {scratch, binary} left one bit, then decrement the counter.
REQ-014 Exactly BIN_W SHIFT iterations SHALL occur; the last one's edge SHALL update bcd and overflow and enter DONE.
REQ-015 done SHALL be high only in DONE: exactly one cycle, BIN_W+1 rising edges after the edge that sampled start.
REQ-016 Conversion throughput SHALL be one result per BIN_W+2 cycles when start is held high.
REQ-017 start SHALL be ignored in SHIFT and DONE; bin changes after capture SHALL NOT affect the result.
REQ-018 bcd and overflow SHALL hold their last value until the next completion; they SHALL NOT change during SHIFT.
REQ-019 Any 1 bit shifted out of the top scratch digit SHALL set sticky overflow; bcd then holds the low DIGITS digits of the true result.
REQ-020 When 10^DIGITS > 2^BIN_W - 1, overflow SHALL be constant 0 for all unsigned inputs.

Reset
REQ-021 rst_n=0 SHALL force, asynchronously, state=IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, scratch=0.
REQ-022 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the block SHALL accept start on the first edge.

Configuration
REQ-023 Macro BIN2BCD_SIGNED_EN defined SHALL make bin two's complement, add output port neg (1 bit, reset 0, updated with bcd), and convert the magnitude.
REQ-024 With BIN2BCD_SIGNED_EN, the magnitude of -2^(BIN_W-1) SHALL convert correctly as an unsigned BIN_W-bit value, and neg SHALL be 0 for a zero result.
REQ-025 Without BIN2BCD_SIGNED_EN, port neg SHALL NOT exist and bin SHALL be unsigned.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE), the BCD digit width constant (4), and the add-3 threshold constant (5).
REQ-027 Sub-module bcd_dabble_digit SHALL implement one combinational digit correction (in >= 5 ? in+3 : in); it SHALL be instantiated DIGITS times in a generate loop.
REQ-028 The counter width SHALL be $clog2(BIN_W+1) bits.

Verification
REQ-029 Defaults, bin=9999, start pulse -> done 15 edges after the start edge, bcd=16'h9999, overflow=0.
REQ-030 bin=0 -> bcd=16'h0000, overflow=0; bin=16383 -> bcd=16'h6383, overflow=1.
REQ-031 start held high for 40 cycles with bin=1234 -> exactly two done pulses 16 cycles apart; start during busy ignored.
REQ-032 rst_n low for 1 cycle at the 7th SHIFT iteration -> no done; bcd=0; new start with bin=42 -> bcd=16'h0042.
REQ-033 BIN2BCD_SIGNED_EN, bin=14'h2000 (-8192) -> neg=1, bcd=16'h8192; bin=-1 -> neg=1, bcd=16'h0001.
REQ-034 BIN_W=8, DIGITS=3, exhaustive bins 0..255 -> bcd matches a decimal reference model, overflow always 0.
